// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction and drives datapath strobes and ALUOp.
// Optional feature: define MC_JAL_EN to support jal (JALWB state); otherwise jal decodes as illegal.
module multicycle_ctrl (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       pc_write_cond_o,
   output logic [1:0] pc_src_o,
   output logic       i_or_d_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic [1:0] reg_dst_o,
   output logic [1:0] mem_to_reg_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic       instr_done_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_JAL_EN
   localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

   localparam logic [2:0] ALU_FUNCT = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_ADDI  = 3'b010;
   localparam logic [2:0] ALU_SLTI  = 3'b011;
   localparam logic [2:0] ALU_ADD   = 3'b100;
   localparam logic [2:0] ALU_JUMP  = 3'b101;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11,
      S_JALWB  = 4'd12
   } state_t;

   state_t state_reg;
   state_t state_next;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg <= S_FETCH;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = S_FETCH;
      case (state_reg)
         S_FETCH:  state_next = mem_ready_i ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode_i)
               OP_LW, OP_SW:     state_next = S_MEMADR;
               OP_R:             state_next = S_EXEC;
               OP_BEQ:           state_next = S_BRANCH;
               OP_J:             state_next = S_JUMP;
               OP_ADDI, OP_SLTI: state_next = S_IEXEC;
`ifdef MC_JAL_EN
               OP_JAL:           state_next = S_JALWB;
`endif
               default:          state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            if (opcode_i == OP_LW) begin
               state_next = S_MEMRD;
            end else if (opcode_i == OP_SW) begin
               state_next = S_MEMWR;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_MEMRD:  state_next = mem_ready_i ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_next = mem_ready_i ? S_FETCH : S_MEMWR;
         S_EXEC:   state_next = S_ALUWB;
         S_IEXEC:  state_next = S_IWB;
         default:  state_next = S_FETCH;
      endcase
   end

   // Opcodes DECODE can dispatch; everything else raises illegal_o.
   function automatic logic is_legal(input logic [5:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_JAL_EN
         OP_JAL: ok = 1'b1;
`endif
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Outputs are forced low while rst_i is high so that FETCH strobes
   // never leak out during reset, even though state_reg already reads FETCH.
   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      pc_src_o        = 2'b00;
      i_or_d_o        = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      reg_dst_o       = 2'b00;
      mem_to_reg_o    = 2'b00;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = 2'b00;
      alu_op_o        = 3'b000;
      instr_done_o    = 1'b0;
      illegal_o       = 1'b0;
      state_o         = 4'd0;
      if (!rst_i) begin
         state_o = state_reg;
         case (state_reg)
            S_FETCH: begin
               mem_read_o  = 1'b1;
               alu_src_b_o = 2'b01;
               alu_op_o    = ALU_ADD;
               ir_write_o  = mem_ready_i;
               pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
               alu_src_b_o = 2'b11;
               alu_op_o    = ALU_ADD;
               if (!is_legal(opcode_i)) begin
                  illegal_o    = 1'b1;
                  instr_done_o = 1'b1;
               end
            end
            S_MEMADR: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = 2'b10;
               alu_op_o    = ALU_ADD;
            end
            S_MEMRD: begin
               mem_read_o = 1'b1;
               i_or_d_o   = 1'b1;
            end
            S_MEMWB: begin
               mem_to_reg_o = 2'b01;
               reg_write_o  = 1'b1;
               instr_done_o = 1'b1;
            end
            S_MEMWR: begin
               mem_write_o  = 1'b1;
               i_or_d_o     = 1'b1;
               instr_done_o = mem_ready_i;
            end
            S_EXEC: begin
               alu_src_a_o = 1'b1;
               alu_op_o    = ALU_FUNCT;
            end
            S_ALUWB: begin
               reg_dst_o    = 2'b01;
               reg_write_o  = 1'b1;
               instr_done_o = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a_o     = 1'b1;
               alu_op_o        = ALU_SUB;
               pc_write_cond_o = 1'b1;
               pc_src_o        = 2'b01;
               instr_done_o    = 1'b1;
            end
            S_JUMP: begin
               alu_op_o     = ALU_JUMP;
               pc_write_o   = 1'b1;
               pc_src_o     = 2'b10;
               instr_done_o = 1'b1;
            end
            S_IEXEC: begin
               alu_src_a_o = 1'b1;
               alu_src_b_o = 2'b10;
               alu_op_o    = (opcode_i == OP_SLTI) ? ALU_SLTI : ALU_ADDI;
            end
            S_IWB: begin
               reg_write_o  = 1'b1;
               instr_done_o = 1'b1;
            end
`ifdef MC_JAL_EN
            // $31 is written from the PC register itself, which still holds
            // PC+4 because the PC load happens on the same edge.
            S_JALWB: begin
               alu_op_o     = ALU_JUMP;
               reg_dst_o    = 2'b10;
               mem_to_reg_o = 2'b10;
               reg_write_o  = 1'b1;
               pc_write_o   = 1'b1;
               pc_src_o     = 2'b10;
               instr_done_o = 1'b1;
            end
`endif
            default: begin
               state_o = state_reg;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an instruction-level model queues the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       done;
      logic       illegal;
      logic [3:0] state;
   } out_t;

   logic       clk;
   logic       rst_i;
   logic [5:0] opcode_i;
   logic       mem_ready_i;
   logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o;
   logic       ir_write_o, reg_write_o, alu_src_a_o, instr_done_o, illegal_o;
   logic [1:0] pc_src_o, reg_dst_o, mem_to_reg_o, alu_src_b_o;
   logic [2:0] alu_op_o;
   logic [3:0] state_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   out_t sb_q[$];

   multicycle_ctrl dut (
      .clk_i(clk), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
      .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .pc_src_o(pc_src_o),
      .i_or_d_o(i_or_d_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
      .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
      .alu_op_o(alu_op_o), .instr_done_o(instr_done_o), .illegal_o(illegal_o),
      .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011;

   function automatic bit jal_enabled();
`ifdef MC_JAL_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit legal(input logic [5:0] op);
      logic [5:0] ops[8] = '{OP_R, OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL};
      foreach (ops[i]) begin
         if (ops[i] == op && (op != OP_JAL || jal_enabled())) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Expected outputs for one cycle in state s, straight from the output table.
   function automatic out_t exp_out(input int s, input bit rdy, input logic [5:0] op);
      out_t o = '0;
      o.state = 4'(s);
      case (s)
         0: begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = 3'b100; o.ir_write = rdy; o.pc_write = rdy; end
         1: begin o.alu_src_b = 2'b11; o.alu_op = 3'b100; o.illegal = !legal(op); o.done = !legal(op); end
         2: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = 3'b100; end
         3: begin o.mem_read = 1; o.i_or_d = 1; end
         4: begin o.mem_to_reg = 2'b01; o.reg_write = 1; o.done = 1; end
         5: begin o.mem_write = 1; o.i_or_d = 1; o.done = rdy; end
         6: begin o.alu_src_a = 1; o.alu_op = 3'b000; end
         7: begin o.reg_dst = 2'b01; o.reg_write = 1; o.done = 1; end
         8: begin o.alu_src_a = 1; o.alu_op = 3'b001; o.pc_write_cond = 1; o.pc_src = 2'b01; o.done = 1; end
         9: begin o.alu_op = 3'b101; o.pc_write = 1; o.pc_src = 2'b10; o.done = 1; end
         10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = (op == OP_SLTI) ? 3'b011 : 3'b010; end
         11: begin o.reg_write = 1; o.done = 1; end
         12: begin o.alu_op = 3'b101; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.reg_write = 1;
                   o.pc_write = 1; o.pc_src = 2'b10; o.done = 1; end
         default: o = '0;
      endcase
      return o;
   endfunction

   task automatic step(input bit rst, input bit rdy, input logic [5:0] op, input out_t e);
      @(posedge clk);
      #1;
      rst_i = rst;
      mem_ready_i = rdy;
      opcode_i = op;
      sb_q.push_back(e);
   endtask

   task automatic st(input int s, input logic [5:0] op);
      bit r = 1'($urandom);
      step(0, r, op, exp_out(s, r, op));
   endtask

   task automatic mem_wait(input int s, input int waits, input logic [5:0] op);
      for (int i = 0; i < waits; i++) step(0, 0, op, exp_out(s, 0, op));
      step(0, 1, op, exp_out(s, 1, op));
   endtask

   // Instruction-level model: the cycle sequence each opcode must produce.
   task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
      for (int i = 0; i < fw; i++) step(0, 0, 6'($urandom), exp_out(0, 0, 0));
      step(0, 1, 6'($urandom), exp_out(0, 1, 0));
      st(1, op);
      if (legal(op)) begin
         case (op)
            OP_LW:           begin st(2, op); mem_wait(3, mw, op); st(4, op); end
            OP_SW:           begin st(2, op); mem_wait(5, mw, op); end
            OP_R:            begin st(6, op); st(7, op); end
            OP_ADDI, OP_SLTI: begin st(10, op); st(11, op); end
            OP_BEQ:          st(8, op);
            OP_J:            st(9, op);
            OP_JAL:          st(12, op);
            default:         ;
         endcase
      end
   endtask

   always @(negedge clk) begin
      out_t act, e;
      cyc++;
      act = '{pc_write_o, pc_write_cond_o, pc_src_o, i_or_d_o, mem_read_o, mem_write_o,
              ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
              alu_op_o, instr_done_o, illegal_o, state_o};
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n_checks++;
         if (act !== e) begin
            n_errors++;
            $display("FAIL outputs cyc=%0d state got=%0d exp=%0d vec got=%h exp=%h", cyc, act.state, e.state, act, e);
         end
      end
   end

   initial begin
      logic [5:0] ops[9] = '{OP_LW, OP_SW, OP_R, OP_ADDI, OP_SLTI, OP_BEQ, OP_J, OP_JAL, 6'b111111};
      logic [5:0] op;
      rst_i = 1'b1;
      mem_ready_i = 1'b1;
      opcode_i = 6'b0;
      step(1, 1, 6'b0, '0);
      step(1, 1, 6'b0, '0);

      // Directed: lw, sw with two waits, R/addi/slti, beq, j, jal, illegal
      run_instr(OP_LW, 0, 0);
      run_instr(OP_SW, 0, 2);
      run_instr(OP_R, 0, 0);
      run_instr(OP_ADDI, 0, 0);
      run_instr(OP_SLTI, 0, 0);
      run_instr(OP_BEQ, 1, 0);
      run_instr(OP_J, 0, 0);
      run_instr(OP_JAL, 0, 0);
      run_instr(6'b111111, 0, 0);

      // Reset aborts an R-type in EXEC; no write-back follows
      step(0, 1, 6'h15, exp_out(0, 1, 0));
      st(1, OP_R);
      for (int i = 0; i < 3; i++) step(1, 1, OP_R, '0);
      run_instr(OP_R, 0, 0);

      // Randomized instruction stream
      for (int n = 0; n < 200; n++) begin
         op = ops[$urandom_range(0, 8)];
         if (op == 6'b111111) begin
            do op = 6'($urandom); while (legal(op));
         end
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end

      @(posedge clk);
      for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain got=%0d pending exp=0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. Sequences FETCH/DECODE/execute/write-back per instruction from the IR opcode, drives all datapath strobes and muxes, and issues the 3-bit ALUOp that the ALU controller consumes. It is the producing end of the ALUOp interface. Memory states stall on a ready handshake.

## Interface
- No parameters.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- opcode_i  in  6  IR[31:26], stable from the cycle after FETCH completes
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero
- pc_src_o  out  2  00 ALU result, 01 ALUOut, 10 jump target
- i_or_d_o  out  1  memory address: 0 PC, 1 ALUOut
- mem_read_o / mem_write_o  out  1 each  memory strobes
- ir_write_o  out  1  IR load
- reg_dst_o  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 10 PC
- reg_write_o  out  1  register file write
- alu_src_a_o  out  1  0 PC, 1 rs
- alu_src_b_o  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op_o  out  3  000 R-type(funct), 001 sub(beq), 010 addi, 011 slti, 100 add(lw/sw/PC), 101 j/jal
- instr_done_o  out  1  last cycle of an instruction
- illegal_o  out  1  unsupported opcode seen in DECODE
- state_o  out  4  current state encoding

## Operation
- Opcodes: R 000000, addi 001000, slti 001010, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11, JALWB 12. Unused encodings go to FETCH.
- Outputs are decoded from state, plus opcode_i in IEXEC and mem_ready_i in memory states. Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=100, pc_src=00. ir_write=pc_write=mem_ready_i. Hold until ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=100. Next state: lw/sw to MEMADR, R to EXEC, beq to BRANCH, j to JUMP, addi/slti to IEXEC, jal to JALWB. Any other opcode: illegal_o=1, instr_done=1, go to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=100. Next: lw to MEMRD, sw to MEMWR.
- MEMRD: mem_read=1, i_or_d=1. Hold until ready, then go to MEMWB.
- MEMWB: reg_dst=00, mem_to_reg=01, reg_write=1, done.
- MEMWR: mem_write=1, i_or_d=1. Hold until ready. done=mem_ready_i.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=000. Then ALUWB: reg_dst=01, mem_to_reg=00, reg_write=1, done.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=010 (addi) or 011 (slti). Then IWB: reg_dst=00, mem_to_reg=00, reg_write=1, done.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01, done.
- JUMP: alu_op=101, pc_write=1, pc_src=10, done.
- JALWB: alu_op=101, reg_dst=10, mem_to_reg=10, reg_write=1, pc_write=1, pc_src=10, done. The register write uses the old PC+4, captured before the PC update.
- Every state that asserts done has FETCH as its next state.

## Timing
- Reset: while rst_i=1, state is FETCH and every output is 0, including state_o=0. First fetch strobes appear in the cycle after rst_i falls.
- Reset mid-instruction aborts immediately. No partial write-back occurs after reset asserts.
- Cycles per instruction with zero wait states: lw 5, sw/R/addi/slti 4, beq/j/jal 3.
- Each low cycle of mem_ready_i adds one cycle in FETCH, MEMRD or MEMWR. Strobes stay asserted and constant while waiting.
- illegal_o and instr_done_o are single-cycle pulses.

## Configuration
- MC_JAL_EN defined: jal decodes to JALWB as above.
- MC_JAL_EN undefined: JALWB does not exist, and jal (000011) is treated as illegal (illegal_o pulse, return to FETCH).

## Test plan
- Reset with rst_i=1 for 3 cycles mid-EXEC -> all outputs 0 and state_o=0 immediately; FETCH strobes (mem_read=1, alu_op=100) appear the cycle after release.
- lw (100011), mem_ready_i=1 -> states 0,1,2,3,4; MEMWB has reg_write=1, mem_to_reg=01, instr_done=1.
- sw with mem_ready_i low for 2 cycles in MEMWR -> mem_write=1 held 3 cycles; done only on the ready cycle; 6 cycles total.
- R-type, then addi, then slti -> EXEC alu_op=000; IEXEC alu_op=010, then 011; write-back reg_dst 01 / 00 / 00.
- beq -> BRANCH alu_op=001, pc_write_cond=1, pc_src=01; j -> JUMP pc_write=1, pc_src=10, alu_op=101.
- jal with MC_JAL_EN -> JALWB reg_dst=10, mem_to_reg=10, pc_write=1. Without the macro, and for opcode 111111 -> illegal_o pulse in DECODE, next state FETCH.
